dma_channel_scheduler: RTL and testbench

Four-channel descriptor scheduler in front of the single-channel DMA controller. Software programs per-channel source/destination/size descriptors and sets GO bits through a simple register write port. The block then serialises the pending channels onto the controller using round-robin arbitration and reports per-channel done/error status and an interrupt. It owns the controller's `dma_request`, `start_transfer`, `src_addr`, `dest_addr` and `transfer_size` inputs.

---
 rtl/dma_channel_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler
//
// Four-channel descriptor scheduler placed in front of a single-channel DMA
// controller. Software loads per-channel SRC/DST/SIZE descriptors and sets
// GO bits through a register write port. Pending channels are serialised
// onto the controller with round-robin arbitration. Per-channel done/error
// status is kept as sticky flags, and an interrupt is raised from them.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   cfg_we            register write strobe
//   cfg_addr[3:2]     channel select
//   cfg_addr[1:0]     register select: 0 SRC, 1 DST, 2 SIZE, 3 CTRL
//   cfg_wdata         write data (SIZE uses [LEN_W-1:0])
//                     CTRL bits: 0 GO, 1 irq_en, 8 W1C done, 9 W1C err
//   dma_request       request to the controller, high for a whole launch
//   start_transfer    one-cycle launch strobe to the controller
//   src_addr          source address of the launched channel
//   dest_addr         destination address of the launched channel
//   transfer_size     word count of the launched channel
//   dma_ack           controller acknowledge; status only, not used here
//   transfer_done     one-cycle completion pulse from the controller
//   ch_pending        GO accepted, not yet finished
//   ch_done           sticky completion flags
//   ch_err            sticky error flags (zero-size descriptor)
//   busy              a channel is launched on the controller
//   active_ch         channel most recently granted
//   irq               OR over channels of (done | err) & irq_en
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | nothing launched; grants the next pending channel
// S_LAUNCH | start_transfer high for this single cycle
// S_BUSY   | dma_request held until the controller reports completion

module dma_channel_scheduler #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic              dma_request,
   output logic              start_transfer,
   output logic [ADDR_W-1:0] src_addr,
   output logic [ADDR_W-1:0] dest_addr,
   output logic [LEN_W-1:0]  transfer_size,
   input  logic              dma_ack,
   input  logic              transfer_done,
   output logic [NUM_CH-1:0] ch_pending,
   output logic [NUM_CH-1:0] ch_done,
   output logic [NUM_CH-1:0] ch_err,
   output logic              busy,
   output logic [1:0]        active_ch,
   output logic              irq
);

   localparam logic [1:0] REG_SRC  = 2'd0;
   localparam logic [1:0] REG_DST  = 2'd1;
   localparam logic [1:0] REG_SIZE = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_BUSY   = 2'd2
   } state_t;

   state_t            state;

   logic [ADDR_W-1:0] src_q  [NUM_CH];
   logic [ADDR_W-1:0] dst_q  [NUM_CH];
   logic [LEN_W-1:0]  size_q [NUM_CH];
   logic [NUM_CH-1:0] irq_en_q;
   logic [1:0]        last_grant;

   logic [1:0]        cfg_ch;
   logic [1:0]        cfg_reg;
   logic              ctrl_wr;
   logic              desc_wr;

   logic              grant_valid;
   logic [1:0]        grant_ch;
   logic              zero_grant;
   logic              finish;

   logic [NUM_CH-1:0] go_set;
   logic [NUM_CH-1:0] pend_clr;
   logic [NUM_CH-1:0] done_set;
   logic [NUM_CH-1:0] done_clr;
   logic [NUM_CH-1:0] err_set;
   logic [NUM_CH-1:0] err_clr;

   // The acknowledge is informational only; sequencing relies on transfer_done.
   logic              unused_dma_ack;
   assign unused_dma_ack = dma_ack;

   // Address decode. Descriptor writes to a pending channel are dropped so the
   // values captured at grant time cannot change underneath a queued request.
   always_comb begin
      cfg_ch  = cfg_addr[3:2];
      cfg_reg = cfg_addr[1:0];
      ctrl_wr = cfg_we && (cfg_reg == REG_CTRL);
      desc_wr = cfg_we && (cfg_reg != REG_CTRL) && !ch_pending[cfg_ch];
   end

   // Round-robin search starting one past the previous grant.
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = last_grant;
      for (int i = 1; i <= NUM_CH; i++) begin
         if (!grant_valid && ch_pending[last_grant + 2'(i)]) begin
            grant_valid = 1'b1;
            grant_ch    = last_grant + 2'(i);
         end
      end
   end

   // A zero-length descriptor is retired at grant time instead of being handed
   // to the controller, whose word counter would otherwise wrap.
   always_comb begin
      zero_grant = (state == S_IDLE) && grant_valid && (size_q[grant_ch] == '0);
      finish     = (state == S_BUSY) && transfer_done;
   end

   // Per-channel flag set/clear terms. A GO on an already pending channel
   // (including the active one) is dropped here.
   always_comb begin
      go_set   = '0;
      pend_clr = '0;
      done_set = '0;
      done_clr = '0;
      err_set  = '0;
      err_clr  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ctrl_wr && (cfg_ch == 2'(c))) begin
            go_set[c]   = cfg_wdata[0] && !ch_pending[c];
            done_clr[c] = cfg_wdata[8];
            err_clr[c]  = cfg_wdata[9];
         end
         if (zero_grant && (grant_ch == 2'(c))) begin
            pend_clr[c] = 1'b1;
            done_set[c] = 1'b1;
            err_set[c]  = 1'b1;
         end
         if (finish && (active_ch == 2'(c))) begin
            pend_clr[c] = 1'b1;
            done_set[c] = 1'b1;
         end
      end
   end

   // Register file and status flags. Hardware set terms are OR'd after the
   // W1C mask so a completion in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            src_q[c]  <= '0;
            dst_q[c]  <= '0;
            size_q[c] <= '0;
         end
         irq_en_q   <= '0;
         ch_pending <= '0;
         ch_done    <= '0;
         ch_err     <= '0;
      end else begin
         if (desc_wr) begin
            case (cfg_reg)
               REG_SRC:  src_q[cfg_ch]  <= cfg_wdata[ADDR_W-1:0];
               REG_DST:  dst_q[cfg_ch]  <= cfg_wdata[ADDR_W-1:0];
               REG_SIZE: size_q[cfg_ch] <= cfg_wdata[LEN_W-1:0];
               default:  ;
            endcase
         end
         if (ctrl_wr) begin
            irq_en_q[cfg_ch] <= cfg_wdata[1];
         end
         ch_pending <= (ch_pending & ~pend_clr) | go_set;
         ch_done    <= (ch_done & ~done_clr) | done_set;
         ch_err     <= (ch_err & ~err_clr) | err_set;
      end
   end

   // Launch sequencer. All controller-facing outputs are registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         last_grant     <= 2'd3;
         active_ch      <= '0;
         dma_request    <= 1'b0;
         start_transfer <= 1'b0;
         busy           <= 1'b0;
         src_addr       <= '0;
         dest_addr      <= '0;
         transfer_size  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               start_transfer <= 1'b0;
               dma_request    <= 1'b0;
               busy           <= 1'b0;
               if (grant_valid) begin
                  last_grant <= grant_ch;
                  active_ch  <= grant_ch;
                  if (!zero_grant) begin
                     src_addr       <= src_q[grant_ch];
                     dest_addr      <= dst_q[grant_ch];
                     transfer_size  <= size_q[grant_ch];
                     start_transfer <= 1'b1;
                     dma_request    <= 1'b1;
                     busy           <= 1'b1;
                     state          <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               start_transfer <= 1'b0;
               state          <= S_BUSY;
            end
            S_BUSY: begin
               if (transfer_done) begin
                  dma_request <= 1'b0;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               start_transfer <= 1'b0;
               dma_request    <= 1'b0;
               busy           <= 1'b0;
               state          <= S_IDLE;
            end
         endcase
      end
   end

   assign irq = |((ch_done | ch_err) & irq_en_q);

endmodule

// File: tb/tb_dma_channel_scheduler.sv
module tb_dma_channel_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic        dma_request;
   logic        start_transfer;
   logic [31:0] src_addr;
   logic [31:0] dest_addr;
   logic [15:0] transfer_size;
   logic        dma_ack;
   logic        transfer_done = 1'b0;
   logic [3:0]  ch_pending;
   logic [3:0]  ch_done;
   logic [3:0]  ch_err;
   logic        busy;
   logic [1:0]  active_ch;
   logic        irq;

   assign dma_ack = dma_request;

   always #5 clk = ~clk;

   dma_channel_scheduler #(.NUM_CH(4), .ADDR_W(32), .LEN_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_we         (cfg_we),
      .cfg_addr       (cfg_addr),
      .cfg_wdata      (cfg_wdata),
      .dma_request    (dma_request),
      .start_transfer (start_transfer),
      .src_addr       (src_addr),
      .dest_addr      (dest_addr),
      .transfer_size  (transfer_size),
      .dma_ack        (dma_ack),
      .transfer_done  (transfer_done),
      .ch_pending     (ch_pending),
      .ch_done        (ch_done),
      .ch_err         (ch_err),
      .busy           (busy),
      .active_ch      (active_ch),
      .irq            (irq)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef struct {
      logic [1:0]  ch;
      logic [31:0] s;
      logic [31:0] d;
      logic [15:0] z;
   } launch_t;

   launch_t     exp_q[$];
   launch_t     got_q[$];
   logic [31:0] m_src[4];
   logic [31:0] m_dst[4];
   logic [15:0] m_size[4];
   logic [3:0]  m_pend, m_done, m_err, m_irqen;
   int          m_last;
   int          m_inflight;

   task automatic m_reset();
      for (int c = 0; c < 4; c++) begin
         m_src[c] = '0; m_dst[c] = '0; m_size[c] = '0;
      end
      m_pend = '0; m_done = '0; m_err = '0; m_irqen = '0;
      m_last = 3; m_inflight = -1;
   endtask

   task automatic m_wr(input int ch, input int rg, input logic [31:0] data);
      if (rg == 3) begin
         if (data[0] && !m_pend[ch]) m_pend[ch] = 1'b1;
         m_irqen[ch] = data[1];
         if (data[8]) m_done[ch] = 1'b0;
         if (data[9]) m_err[ch] = 1'b0;
      end else if (!m_pend[ch]) begin
         if (rg == 0) m_src[ch] = data;
         else if (rg == 1) m_dst[ch] = data;
         else m_size[ch] = data[15:0];
      end
   endtask

   function automatic int m_next();
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (m_last + k) % 4;
         if (m_pend[c] && c != m_inflight) return c;
      end
      return -1;
   endfunction

   task automatic m_grant();
      int c;
      c = m_next();
      if (c < 0) return;
      m_last = c;
      if (m_size[c] == 0) begin
         m_pend[c] = 1'b0; m_done[c] = 1'b1; m_err[c] = 1'b1;
      end else begin
         m_inflight = c;
         exp_q.push_back('{ch: 2'(c), s: m_src[c], d: m_dst[c], z: m_size[c]});
      end
   endtask

   task automatic m_complete();
      if (m_inflight >= 0) begin
         m_pend[m_inflight] = 1'b0;
         m_done[m_inflight] = 1'b1;
         m_inflight = -1;
      end
   endtask

   task automatic m_drain();
      m_complete();
      while (m_next() >= 0) begin
         m_grant();
         m_complete();
      end
   endtask

   // ---------------- bus helpers ----------------
   task automatic wr(input int ch, input int rg, input logic [31:0] data);
      cfg_we    = 1'b1;
      cfg_addr  = {2'(ch), 2'(rg)};
      cfg_wdata = data;
      m_wr(ch, rg, data);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic pulse_done();
      transfer_done = 1'b1;
      tick();
      transfer_done = 1'b0;
   endtask

   // ---------------- launch monitor ----------------
   int   bad_start = 0;
   int   bad_req   = 0;
   logic prev_start = 1'b0;

   always @(negedge clk) begin
      if (start_transfer) begin
         got_q.push_back('{ch: active_ch, s: src_addr, d: dest_addr, z: transfer_size});
         if (prev_start) bad_start++;
      end
      if (dma_request !== busy) bad_req++;
      prev_start = start_transfer;
   end

   initial begin
      #5ms;
      $fatal(1, "FAIL watchdog: simulation time limit reached");
   end

   // ---------------- stimulus ----------------
   initial begin
      int b, cyc, n;
      logic [15:0] sz;

      m_reset();
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_req",   dma_request, 0);
      chk("rst_start", start_transfer, 0);
      chk("rst_src",   src_addr, 0);
      chk("rst_dst",   dest_addr, 0);
      chk("rst_size",  transfer_size, 0);
      chk("rst_pend",  ch_pending, 0);
      chk("rst_done",  ch_done, 0);
      chk("rst_err",   ch_err, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_act",   active_ch, 0);
      chk("rst_irq",   irq, 0);

      // basic ch0 launch with exact edge timing
      wr(0, 0, 32'h1000); wr(0, 1, 32'h2000); wr(0, 2, 3);
      wr(0, 3, 1);
      chk("t2_pend_after_go", ch_pending, 4'b0001);
      chk("t2_start_early", start_transfer, 0);
      tick();
      chk("t2_start", start_transfer, 1);
      chk("t2_req",   dma_request, 1);
      chk("t2_src",   src_addr, 32'h1000);
      chk("t2_dst",   dest_addr, 32'h2000);
      chk("t2_size",  transfer_size, 3);
      chk("t2_busy",  busy, 1);
      tick();
      chk("t2_start_drop", start_transfer, 0);
      chk("t2_req_hold",   dma_request, 1);
      tick(); tick();
      chk("t2_req_hold2",  dma_request, 1);
      pulse_done();
      chk("t2_req_drop", dma_request, 0);
      chk("t2_done",     ch_done, 4'b0001);
      chk("t2_busy_end", busy, 0);
      chk("t2_pend_end", ch_pending, 0);

      // zero-size ch2
      wr(2, 2, 0);
      wr(2, 3, 1);
      chk("t3_pend", ch_pending, 4'b0100);
      tick();
      chk("t3_pend_clr", ch_pending, 0);
      chk("t3_err",      ch_err, 4'b0100);
      chk("t3_done",     ch_done, 4'b0101);
      chk("t3_nostart",  start_transfer, 0);
      chk("t3_busy",     busy, 0);
      chk("t3_act",      active_ch, 2);

      // locked descriptor, ignored GO, W1C vs hardware set
      wr(1, 0, 32'hA); wr(1, 1, 32'hB); wr(1, 2, 5); wr(1, 3, 1);
      tick(); tick();
      wr(1, 0, 32'hBEEF);
      wr(1, 3, 1);
      chk("t4_src_hold", src_addr, 32'hA);
      pulse_done();
      repeat (3) tick();
      chk("t4_regoignored_busy", busy, 0);
      chk("t4_regoignored_pend", ch_pending, 0);
      wr(0, 3, 32'h100);
      chk("t4_w1c", ch_done, 4'b0110);
      wr(0, 3, 1);
      tick(); tick();
      transfer_done = 1'b1;
      wr(0, 3, 32'h100);
      transfer_done = 1'b0;
      chk("t4_set_wins", ch_done[0], 1);
      wr(1, 3, 1);
      tick();
      chk("t4_locked_src", src_addr, 32'hA);
      tick();
      pulse_done();

      // irq on ch3
      wr(3, 2, 2);
      wr(3, 3, 3);
      chk("t5_irq_pre", irq, 0);
      tick(); tick();
      pulse_done();
      chk("t5_irq_set", irq, 1);
      wr(3, 3, 32'h102);
      chk("t5_irq_clr", irq, 0);

      // reset mid-transfer
      wr(0, 3, 1);
      tick(); tick();
      chk("t6_busy_pre", busy, 1);
      reset = 1'b1;
      tick();
      chk("t6_req",   dma_request, 0);
      chk("t6_start", start_transfer, 0);
      chk("t6_src",   src_addr, 0);
      chk("t6_size",  transfer_size, 0);
      chk("t6_flags", {ch_pending, ch_done, ch_err}, 0);
      chk("t6_busy",  busy, 0);
      chk("t6_irq",   irq, 0);
      reset = 1'b0;
      m_reset();
      wr(0, 0, 32'h55); wr(0, 2, 4); wr(0, 3, 1);
      tick();
      chk("t6_regrant_ch", active_ch, 0);
      chk("t6_regrant_src", src_addr, 32'h55);
      tick();
      pulse_done();

      // randomized rounds against the model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_reset();
      for (int r = 0; r < 10; r++) begin
         got_q.delete();
         exp_q.delete();
         for (int c = 0; c < 4; c++) begin
            wr(c, 0, $urandom);
            wr(c, 1, $urandom);
            sz = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            wr(c, 2, {16'($urandom_range(0, 65535)), sz});
         end
         b = $urandom_range(0, 3);
         if (m_size[b] == 0) wr(b, 2, 7);
         wr(b, 3, ($urandom & 32'h302) | 32'h1);
         m_grant();
         n = $urandom_range(3, 7);
         for (int k = 0; k < n; k++) begin
            int c;
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) wr(c, 0, $urandom);
            else wr(c, 3, $urandom & 32'h303);
         end
         m_drain();
         cyc = 0;
         while ((busy || ch_pending != 0) && cyc < 3000) begin
            transfer_done = ($urandom_range(0, 2) == 0);
            tick();
            transfer_done = 1'b0;
            cyc++;
         end
         chk("rnd_drain_bound", cyc < 3000, 1);
         tick();
         chk("rnd_launch_count", got_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("rnd_ch",   got_q[i].ch, exp_q[i].ch);
            chk("rnd_src",  got_q[i].s,  exp_q[i].s);
            chk("rnd_dst",  got_q[i].d,  exp_q[i].d);
            chk("rnd_size", got_q[i].z,  exp_q[i].z);
         end
         chk("rnd_pend", ch_pending, m_pend);
         chk("rnd_done", ch_done, m_done);
         chk("rnd_err",  ch_err, m_err);
         chk("rnd_irq",  irq, |((m_done | m_err) & m_irqen));
      end

      chk("start_one_cycle", bad_start, 0);
      chk("req_matches_busy", bad_req, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
